// File: rtl/clock_pkg.sv
// Shared types and limits for the time-of-day controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } clk_mode_t;

  localparam logic [4:0] MAX_HOURS   = 5'd23;
  localparam logic [5:0] MAX_MINUTES = 6'd59;
  localparam logic [5:0] MAX_SECONDS = 6'd59;

  // True when an RTC snapshot holds a legal time of day.
  function automatic logic rtc_fields_ok(input logic [5:0] h,
                                         input logic [5:0] m,
                                         input logic [5:0] s);
    return (h <= {1'b0, MAX_HOURS}) && (m <= MAX_MINUTES) && (s <= MAX_SECONDS);
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detector with hold-to-repeat for a debounced button level.
module btn_repeat #(
  parameter int unsigned REPEAT_DLY  = 25_000_000,
  parameter int unsigned REPEAT_RATE = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic ev_o
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic          btn_q;
  logic          ev_q;
  logic          rep_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] limit;

  // Cycles between events: initial delay first, then the repeat rate.
  always_comb begin
    limit = rep_q ? CW'(REPEAT_RATE - 1) : CW'(REPEAT_DLY - 1);
  end

  // Edge detect, then count held cycles since the last event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= 1'b0;
      ev_q  <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn_i;
      ev_q  <= 1'b0;
      if (btn_i && !btn_q) begin
        ev_q  <= 1'b1;
        cnt_q <= '0;
        rep_q <= 1'b0;
      end else if (btn_i) begin
        if (cnt_q == limit) begin
          ev_q  <= 1'b1;
          cnt_q <= '0;
          rep_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
        rep_q <= 1'b0;
      end
    end
  end

  assign ev_o = ev_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Time-of-day keeper with two-button set mode and RTC snapshot loading.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = 12_500_000,
  parameter int unsigned REPEAT_DLY  = 25_000_000,
  parameter int unsigned REPEAT_RATE = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       rtc_load,
  input  logic [5:0] rtc_hours,
  input  logic [5:0] rtc_minutes,
  input  logic [5:0] rtc_seconds,
  output logic [4:0] time_hours,
  output logic [5:0] time_minutes,
  output logic [5:0] time_seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       time_valid,
  output logic       rtc_ack,
  output logic       rtc_err
);

  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  clk_mode_t     mode_q;
  logic [4:0]    hr_q, hr_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          blink_q, valid_q, ack_q, err_q;
  logic [BW-1:0] bcnt_q;
  logic          bm_q, mode_ev_q;
  logic          inc_ev;

  btn_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_inc (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_inc),
    .ev_o  (inc_ev)
  );

  // Time advanced by one second with full carry chain.
  always_comb begin
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q + 6'd1;
    if (sec_q == MAX_SECONDS) begin
      sec_d = '0;
      if (min_q == MAX_MINUTES) begin
        min_d = '0;
        hr_d  = (hr_q == MAX_HOURS) ? '0 : hr_q + 5'd1;
      end else begin
        min_d = min_q + 6'd1;
      end
    end
  end

  // Mode FSM, time registers, RTC handshake and blink timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_RUN;
      hr_q      <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      blink_q   <= 1'b0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      bcnt_q    <= '0;
      bm_q      <= 1'b0;
      mode_ev_q <= 1'b0;
    end else begin
      bm_q      <= btn_mode;
      mode_ev_q <= btn_mode & ~bm_q;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      unique case (mode_q)
        MODE_RUN: begin
          blink_q <= 1'b0;
          bcnt_q  <= '0;
          if (mode_ev_q) begin
            mode_q  <= MODE_SET_H;
            blink_q <= 1'b1;
          end else if (rtc_load) begin
            if (rtc_fields_ok(rtc_hours, rtc_minutes, rtc_seconds)) begin
              hr_q    <= rtc_hours[4:0];
              min_q   <= rtc_minutes;
              sec_q   <= rtc_seconds;
              ack_q   <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (tick) begin
            hr_q  <= hr_d;
            min_q <= min_d;
            sec_q <= sec_d;
          end
        end
        MODE_SET_H, MODE_SET_M: begin
          if (mode_ev_q) begin
            bcnt_q <= '0;
            if (mode_q == MODE_SET_H) begin
              mode_q  <= MODE_SET_M;
              blink_q <= 1'b1;
            end else begin
              mode_q  <= MODE_RUN;
              sec_q   <= '0;
              valid_q <= 1'b1;
              blink_q <= 1'b0;
            end
          end else if (inc_ev) begin
            if (mode_q == MODE_SET_H)
              hr_q <= (hr_q == MAX_HOURS) ? '0 : hr_q + 5'd1;
            else
              min_q <= (min_q == MAX_MINUTES) ? '0 : min_q + 6'd1;
            blink_q <= 1'b1;
            bcnt_q  <= '0;
          end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_q  <= '0;
            blink_q <= ~blink_q;
          end else begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        default: mode_q <= MODE_RUN;
      endcase
    end
  end

  assign time_hours   = hr_q;
  assign time_minutes = min_q;
  assign time_seconds = sec_q;
  assign mode         = mode_q;
  assign blink        = blink_q;
  assign time_valid   = valid_q;
  assign rtc_ack      = ack_q;
  assign rtc_err      = err_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Scoreboard bench for clock_time_ctrl against a seconds-of-day reference model.
module tb_clock_time_ctrl;

  localparam int BDIV  = 6;
  localparam int RDLY  = 20;
  localparam int RRATE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, rtc_load = 1'b0;
  logic [5:0] rtc_hours = '0, rtc_minutes = '0, rtc_seconds = '0;
  logic [4:0] time_hours;
  logic [5:0] time_minutes, time_seconds;
  logic [1:0] mode;
  logic       blink, time_valid, rtc_ack, rtc_err;

  clock_time_ctrl #(
    .BLINK_DIV   (BDIV),
    .REPEAT_DLY  (RDLY),
    .REPEAT_RATE (RRATE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .rtc_load     (rtc_load),
    .rtc_hours    (rtc_hours),
    .rtc_minutes  (rtc_minutes),
    .rtc_seconds  (rtc_seconds),
    .time_hours   (time_hours),
    .time_minutes (time_minutes),
    .time_seconds (time_seconds),
    .mode         (mode),
    .blink        (blink),
    .time_valid   (time_valid),
    .rtc_ack      (rtc_ack),
    .rtc_err      (rtc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, m, s, md, bl, vl, ak, er;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: time as seconds of day, events as held-cycle counts.
  int m_secs, m_mode, m_valid, m_ack, m_err, m_blink, m_bn, m_held;
  bit m_mev, m_iev, m_pmode;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_mode = 0; m_valid = 0; m_ack = 0; m_err = 0;
    m_blink = 0; m_bn = 0; m_held = 0;
    m_mev = 1'b0; m_iev = 1'b0; m_pmode = 1'b0;
  endtask

  task automatic model_step(input bit tk, input bit bm, input bit bi, input bit ld,
                            input int rh, input int rm, input int rs);
    int hh, mm, ss;
    hh = m_secs / 3600;
    mm = (m_secs / 60) % 60;
    ss = m_secs % 60;
    m_ack = 0;
    m_err = 0;
    if (m_mode == 0) begin
      m_blink = 0;
      m_bn    = 0;
      if (m_mev) begin
        m_mode  = 1;
        m_blink = 1;
      end else if (ld) begin
        if (rh < 24 && rm < 60 && rs < 60) begin
          m_secs = rh * 3600 + rm * 60 + rs;
          m_ack = 1;
          m_valid = 1;
        end else begin
          m_err = 1;
        end
      end else if (tk) begin
        m_secs = (m_secs + 1) % 86400;
      end
    end else if (m_mev) begin
      m_bn = 0;
      if (m_mode == 1) begin
        m_mode = 2; m_blink = 1;
      end else begin
        m_mode = 0; m_secs = m_secs - ss; m_valid = 1; m_blink = 0;
      end
    end else if (m_iev) begin
      if (m_mode == 1) hh = (hh + 1) % 24;
      else             mm = (mm + 1) % 60;
      m_secs  = hh * 3600 + mm * 60 + ss;
      m_blink = 1;
      m_bn    = 0;
    end else begin
      m_bn++;
      m_blink = ((m_bn / BDIV) % 2 == 0) ? 1 : 0;
    end
    m_mev   = bm && !m_pmode;
    m_pmode = bm;
    m_held  = bi ? m_held + 1 : 0;
    m_iev   = (m_held == 1) || (m_held > RDLY && (m_held - 1 - RDLY) % RRATE == 0);
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input bit tk, input bit bm, input bit bi, input bit ld,
                     input int rh = 0, input int rm = 0, input int rs = 0);
    exp_t e;
    @(negedge clk);
    tick = tk; btn_mode = bm; btn_inc = bi; rtc_load = ld;
    rtc_hours = 6'(rh); rtc_minutes = 6'(rm); rtc_seconds = 6'(rs);
    model_step(tk, bm, bi, ld, rh, rm, rs);
    e.h = m_secs / 3600; e.m = (m_secs / 60) % 60; e.s = m_secs % 60;
    e.md = m_mode; e.bl = m_blink; e.vl = m_valid; e.ak = m_ack; e.er = m_err;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit tk = 1'b0);
    for (int i = 0; i < n; i++) cyc(tk, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
  endtask

  task automatic press_inc(input bit tk);
    cyc(tk, 0, 1, 0); cyc(tk, 0, 1, 0); cyc(tk, 0, 0, 0); cyc(tk, 0, 0, 0);
  endtask

  task automatic zero_outputs_chk(input string tag);
    chk({tag, "_hours"}, int'(time_hours), 0);
    chk({tag, "_minutes"}, int'(time_minutes), 0);
    chk({tag, "_seconds"}, int'(time_seconds), 0);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_blink"}, int'(blink), 0);
    chk({tag, "_valid"}, int'(time_valid), 0);
    chk({tag, "_ack"}, int'(rtc_ack), 0);
    chk({tag, "_err"}, int'(rtc_err), 0);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("hours", int'(time_hours), e.h);
        chk("minutes", int'(time_minutes), e.m);
        chk("seconds", int'(time_seconds), e.s);
        chk("mode", int'(mode), e.md);
        chk("blink", int'(blink), e.bl);
        chk("time_valid", int'(time_valid), e.vl);
        chk("rtc_ack", int'(rtc_ack), e.ak);
        chk("rtc_err", int'(rtc_err), e.er);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: actual=running expected=finished");
    $fatal(1, "time limit expired");
  end

  initial begin
    bit r_bm, r_bi;
    model_reset();
    #12;
    zero_outputs_chk("reset");
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range load is rejected and leaves time_valid low.
    cyc(0, 0, 0, 1, 24, 10, 10);
    idle(2);
    // 23:59:59 then one tick wraps to midnight.
    cyc(0, 0, 0, 1, 23, 59, 59);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(2);
    // Set hours from 22 with ticks arriving, then watch blink toggle.
    cyc(0, 0, 0, 1, 22, 58, 30);
    idle(1);
    press_mode();
    idle(15, 1'b1);
    for (int i = 0; i < 3; i++) press_inc(1'b1);
    // Set minutes from 58 with a long hold for auto-repeat.
    press_mode();
    for (int i = 0; i < RDLY + 2 * RRATE; i++) cyc(1, 0, 1, 0);
    idle(3);
    press_mode();
    idle(2);
    // Load and tick together: the load wins.
    cyc(0, 0, 0, 1, 10, 0, 5);
    idle(1);
    cyc(1, 0, 0, 1, 12, 0, 0);
    idle(2);
    // Load while editing is ignored.
    press_mode();
    cyc(0, 0, 0, 1, 5, 5, 5);
    idle(2);
    press_mode();
    press_mode();
    idle(2);

    // Asynchronous reset while editing hours.
    press_mode();
    @(posedge clk);
    #3;
    chk("pre_rst_mode", int'(mode), 1);
    chk("pre_rst_blink", int'(blink), 1);
    tick = 0; btn_mode = 0; btn_inc = 0; rtc_load = 0;
    rst = 1'b1;
    #1;
    zero_outputs_chk("async_rst");
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    r_bm = 1'b0;
    r_bi = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit tk, ld;
      int rh, rm, rs;
      if ($urandom_range(0, 39) == 0) r_bm = ~r_bm;
      if ($urandom_range(0, 29) == 0) r_bi = ~r_bi;
      tk = ($urandom_range(0, 3) == 0);
      ld = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rh = $urandom_range(0, 63); rm = $urandom_range(0, 63); rs = $urandom_range(0, 63);
      end else begin
        rh = $urandom_range(0, 23); rm = $urandom_range(0, 59); rs = $urandom_range(0, 59);
      end
      cyc(tk, r_bm, r_bi, ld, rh, rm, rs);
    end
    idle(1);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
